// File: rtl/quad_color_arbiter_if.sv
// Update-request bus between the quadrant color writers and the arbiter.
interface quad_color_arbiter_if;
  logic [3:0] req;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [7:0] wdata2;
  logic [7:0] wdata3;
  logic [3:0] gnt;
  logic       busy;

  modport master (output req, wdata0, wdata1, wdata2, wdata3, input gnt, busy);
  modport slave  (input req, wdata0, wdata1, wdata2, wdata3, output gnt, busy);
endinterface

// File: rtl/quad_color_arbiter.sv
// Four-quadrant VGA colorizer; color updates are arbitrated round-robin and
// committed only during vertical blanking so a visible frame never tears.
module quad_color_arbiter #(
  parameter logic [9:0] HC1    = 10'd317,
  parameter logic [9:0] VC1    = 10'd240,
  parameter logic [9:0] HC2    = 10'd635,
  parameter logic [9:0] VC2    = 10'd480,
  parameter logic [7:0] RST_C0 = 8'hE0,
  parameter logic [7:0] RST_C1 = 8'h1C,
  parameter logic [7:0] RST_C2 = 8'h03,
  parameter logic [7:0] RST_C3 = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           hcnt,
  input  logic [9:0]           vcnt,
  quad_color_arbiter_if.slave  bus,
  output logic [1:0]           quadrant_sel,
  output logic [7:0]           color_out
);
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_BLANK = 2'd1;
  localparam logic [1:0] GRANT      = 2'd2;
  localparam logic [1:0] COMMIT     = 2'd3;

  localparam logic [3:0][7:0] RST_COL = {RST_C3, RST_C2, RST_C1, RST_C0};

  logic [1:0]      state, state_nxt;
  logic [1:0]      ptr, win, w;
  logic [3:0]      req;
  logic [3:0][7:0] wdata;
  logic [3:0][7:0] col;
  logic            blank, right, bottom;
  logic [1:0]      quad;

  assign req    = bus.req;
  assign wdata  = {bus.wdata3, bus.wdata2, bus.wdata1, bus.wdata0};
  assign blank  = (vcnt >= VC2);
  assign right  = (hcnt >= HC1);
  assign bottom = (vcnt >= VC1);
  assign quad   = {bottom, right};

  assign bus.gnt  = (state == GRANT) ? (4'b0001 << w) : 4'b0000;
  assign bus.busy = (state != IDLE);

  // Rotating priority: the lowest offset from ptr wins, so iterate high-to-low.
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (req != 4'b0000) state_nxt = blank ? GRANT : WAIT_BLANK;
      WAIT_BLANK: if (req == 4'b0000) state_nxt = IDLE;
                  else if (blank)     state_nxt = GRANT;
      GRANT:      state_nxt = COMMIT;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      w     <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state != GRANT && state_nxt == GRANT) w <= win;
      if (state == COMMIT) ptr <= w + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= RST_COL;
    end else if (state == GRANT) begin
      col[w] <= wdata[w];
    end
  end

  // Pixel path: one register stage, reads colors as they stood before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quadrant_sel <= 2'd0;
      color_out    <= 8'h00;
    end else begin
      quadrant_sel <= quad;
      color_out    <= (blank || hcnt >= HC2) ? 8'h00 : col[quad];
    end
  end
endmodule

// File: tb/tb_quad_color_arbiter.sv
// Directed bench for quad_color_arbiter with a transaction-level reference model.
module tb_quad_color_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hcnt = 10'd0;
  logic [9:0] vcnt = 10'd0;
  logic [1:0] quadrant_sel;
  logic [7:0] color_out;
  logic [3:0] last_g = 4'b0000;

  int checks = 0;
  int passes = 0;

  quad_color_arbiter_if bus();

  quad_color_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .hcnt         (hcnt),
    .vcnt         (vcnt),
    .bus          (bus),
    .quadrant_sel (quadrant_sel),
    .color_out    (color_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a request is pending until blank, then one grant cycle,
  // one commit cycle, and a mandatory idle cycle before the next winner.
  logic [7:0] m_col [4] = '{8'hE0, 8'h1C, 8'h03, 8'hFF};
  int         m_ptr = 0;
  int         m_stage = 0;   // 0 idle, 1 pending, 2 granting, 3 committing
  int         m_w = 0;
  logic [1:0] m_q = 2'd0;
  logic [7:0] m_color = 8'h00;

  function automatic int rr(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  function automatic logic [7:0] wd(input int i);
    case (i)
      0: return bus.wdata0;
      1: return bus.wdata1;
      2: return bus.wdata2;
      default: return bus.wdata3;
    endcase
  endfunction

  function automatic logic [1:0] qsel(input logic [9:0] h, input logic [9:0] v);
    return {v >= 10'd240, h >= 10'd317};
  endfunction

  function automatic int gidx(input logic [3:0] g);
    for (int k = 0; k < 4; k++) if (g[k]) return k;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_col   <= '{8'hE0, 8'h1C, 8'h03, 8'hFF};
      m_ptr   <= 0;
      m_stage <= 0;
      m_w     <= 0;
      m_q     <= 2'd0;
      m_color <= 8'h00;
    end else begin
      m_q     <= qsel(hcnt, vcnt);
      m_color <= (vcnt >= 10'd480 || hcnt >= 10'd635) ? 8'h00 : m_col[qsel(hcnt, vcnt)];
      case (m_stage)
        0: if (bus.req != 4'b0000) begin
             if (vcnt >= 10'd480) begin m_w <= rr(bus.req, m_ptr); m_stage <= 2; end
             else m_stage <= 1;
           end
        1: if (bus.req == 4'b0000) m_stage <= 0;
           else if (vcnt >= 10'd480) begin m_w <= rr(bus.req, m_ptr); m_stage <= 2; end
        2: begin m_col[m_w] <= wd(m_w); m_stage <= 3; end
        default: begin m_ptr <= (m_w + 1) % 4; m_stage <= 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("model_gnt", int'(bus.gnt), (m_stage == 2) ? (1 << m_w) : 0);
    chk("model_busy", int'(bus.busy), int'(m_stage != 0));
    chk("model_qsel", int'(quadrant_sel), int'(m_q));
    chk("model_color", int'(color_out), int'(m_color));
  end

  // Requester behaviour: a granted bit is dropped in the cycle after its grant.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.req = bus.req & ~last_g;
    last_g  = bus.gnt;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = 4'b0000;
    last_g  = 4'b0000;
    #3;
    reset   = 1'b0;
  endtask

  int gi[$];
  int gc[$];
  int seen;

  initial begin
    bus.req = 4'b0000;
    bus.wdata0 = 8'h00; bus.wdata1 = 8'h00; bus.wdata2 = 8'h00; bus.wdata3 = 8'h00;
    #12;
    chk("rst_qsel", int'(quadrant_sel), 0);
    chk("rst_color", int'(color_out), 0);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;

    // Pixel lookup at reset colors, including exact split boundaries.
    hcnt = 10'd100; vcnt = 10'd100; tick();
    chk("tl_qsel", int'(quadrant_sel), 0);
    chk("tl_color", int'(color_out), 8'hE0);
    hcnt = 10'd317; vcnt = 10'd240; tick();
    chk("br_qsel", int'(quadrant_sel), 3);
    chk("br_color", int'(color_out), 8'hFF);

    // Update requested mid-frame waits for blank.
    bus.req = 4'b0010; bus.wdata1 = 8'h55; vcnt = 10'd100; tick();
    chk("wait_busy", int'(bus.busy), 1);
    chk("wait_gnt", int'(bus.gnt), 0);
    tick();
    chk("wait_gnt2", int'(bus.gnt), 0);
    vcnt = 10'd480; tick();
    chk("blank_gnt", int'(bus.gnt), 4'b0010);
    tick();
    chk("commit_gnt", int'(bus.gnt), 0);
    chk("commit_busy", int'(bus.busy), 1);
    tick();
    chk("idle_busy", int'(bus.busy), 0);
    hcnt = 10'd400; vcnt = 10'd100; tick();
    chk("tr_qsel", int'(quadrant_sel), 1);
    chk("tr_color", int'(color_out), 8'h55);

    // All four request at once: rotating order, 3 cycles apart.
    do_reset();
    bus.wdata0 = 8'h11; bus.wdata1 = 8'h22; bus.wdata2 = 8'h33; bus.wdata3 = 8'h44;
    vcnt = 10'd500; bus.req = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.gnt != 4'b0000) begin gi.push_back(gidx(bus.gnt)); gc.push_back(c); end
    end
    chk("rr_count", gi.size(), 4);
    if (gi.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("rr_order", gi[k], k);
      for (int k = 1; k < 4; k++) chk("rr_spacing", gc[k] - gc[k-1], 3);
    end
    hcnt = 10'd100; vcnt = 10'd100; tick(); chk("rr_col0", int'(color_out), 8'h11);
    hcnt = 10'd400; tick();                 chk("rr_col1", int'(color_out), 8'h22);
    hcnt = 10'd100; vcnt = 10'd300; tick(); chk("rr_col2", int'(color_out), 8'h33);
    hcnt = 10'd400; tick();                 chk("rr_col3", int'(color_out), 8'h44);
    // Pointer back at 0: of quadrants 0 and 2, 0 goes first.
    vcnt = 10'd500; bus.req = 4'b0101;
    gi.delete();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.gnt != 4'b0000) gi.push_back(gidx(bus.gnt));
    end
    chk("ptr_wrap_count", gi.size(), 2);
    if (gi.size() == 2) begin
      chk("ptr_wrap_first", gi[0], 0);
      chk("ptr_wrap_second", gi[1], 2);
    end

    // Request withdrawn before blank: no grant, color unchanged.
    do_reset();
    vcnt = 10'd100; bus.req = 4'b0001; bus.wdata0 = 8'h77; tick();
    chk("abandon_busy", int'(bus.busy), 1);
    bus.req = 4'b0000; tick();
    chk("abandon_idle", int'(bus.busy), 0);
    seen = 0;
    vcnt = 10'd480;
    for (int c = 0; c < 4; c++) begin tick(); if (bus.gnt != 4'b0000) seen++; end
    chk("abandon_nognt", seen, 0);
    hcnt = 10'd100; vcnt = 10'd100; tick();
    chk("abandon_col0", int'(color_out), 8'hE0);

    // Reset during GRANT aborts the write.
    do_reset();
    vcnt = 10'd480; bus.req = 4'b0100; bus.wdata2 = 8'hAA; tick();
    chk("abort_gnt_pre", int'(bus.gnt), 4'b0100);
    reset = 1'b1; bus.req = 4'b0000; #1;
    chk("abort_gnt_rst", int'(bus.gnt), 0);
    chk("abort_busy_rst", int'(bus.busy), 0);
    tick(); reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin tick(); if (bus.gnt != 4'b0000) seen++; end
    chk("abort_nognt", seen, 0);
    hcnt = 10'd100; vcnt = 10'd300; tick();
    chk("abort_qsel", int'(quadrant_sel), 2);
    chk("abort_col2", int'(color_out), 8'h03);

    // Non-visible and boundary pixels.
    hcnt = 10'd640; vcnt = 10'd10;  tick(); chk("hblank_color", int'(color_out), 0);
    hcnt = 10'd100; vcnt = 10'd480; tick(); chk("vblank_color", int'(color_out), 0);
    chk("vblank_qsel", int'(quadrant_sel), 2);
    hcnt = 10'd316; vcnt = 10'd239; tick(); chk("edge_tl_qsel", int'(quadrant_sel), 0);
    chk("edge_tl_color", int'(color_out), 8'hE0);
    hcnt = 10'd634; vcnt = 10'd479; tick(); chk("edge_br_color", int'(color_out), 8'hFF);
    hcnt = 10'd635; tick();                 chk("edge_h2_color", int'(color_out), 0);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
